// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU op encodings and RV32I opcode/funct constants
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - combinational opcode/funct3/funct7 decode to ALU control
module alu_dec
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alucontrol,
  output logic       alusrc,
  output logic       illegal
);

  alu_op_t f3_op;
  logic    f3_ok;
  alu_op_t op_sel;
  logic    src_sel;
  logic    bad;

  always_comb begin
    f3_op = ALU_ADD;
    f3_ok = 1'b1;
    case (funct3)
      F3_ADDSUB: f3_op = ALU_ADD;
      F3_SLT:    f3_op = ALU_SLT;
      F3_XOR:    f3_op = ALU_XOR;
      F3_OR:     f3_op = ALU_OR;
      F3_AND:    f3_op = ALU_AND;
      default:   f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    op_sel  = ALU_ADD;
    src_sel = 1'b0;
    bad     = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: src_sel = 1'b1;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) op_sel = ALU_SUB;
        else                  bad    = 1'b1;
      end
      OP_R: begin
        // only add/sub share funct3 000; funct7 0100000 is legal only there
        if (!f3_ok)                                         bad    = 1'b1;
        else if (funct7 == F7_BASE)                         op_sel = f3_op;
        else if (funct7 == F7_ALT && funct3 == F3_ADDSUB)   op_sel = ALU_SUB;
        else                                                bad    = 1'b1;
      end
      OP_I: begin
        if (f3_ok) begin
          op_sel  = f3_op;
          src_sel = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  assign alucontrol = bad ? ALU_ADD : op_sel;
  assign alusrc     = bad ? 1'b0 : src_sel;
  assign illegal    = bad;

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ALU control decode plus ID/EX pipeline register
module alu_ctrl_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_d,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] immext_d,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic            valid_e,
  output logic [2:0]      alucontrol_e,
  output logic            alusrc_e,
  output logic            illegal_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] immext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [4:0]      rd_e
);

  logic [2:0] alucontrol_d;
  logic       alusrc_d;
  logic       illegal_d;
  logic       unused_rs_bits;

  assign unused_rs_bits = ^instr_d[24:15];

  alu_dec u_alu_dec (
    .op         (instr_d[6:0]),
    .funct3     (instr_d[14:12]),
    .funct7     (instr_d[31:25]),
    .alucontrol (alucontrol_d),
    .alusrc     (alusrc_d),
    .illegal    (illegal_d)
  );

  always_ff @(posedge clk) begin
    // a bubble in decode loads the same state as reset/flush
    if (reset || flush_e || (!stall_e && !valid_d)) begin
      valid_e      <= 1'b0;
      alucontrol_e <= ALU_ADD;
      alusrc_e     <= 1'b0;
      illegal_e    <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      immext_e     <= '0;
      pc_e         <= RESET_PC;
      rd_e         <= '0;
    end else if (!stall_e) begin
      valid_e      <= 1'b1;
      alucontrol_e <= alucontrol_d;
      alusrc_e     <= alusrc_d;
      illegal_e    <= illegal_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      immext_e     <= immext_d;
      pc_e         <= pc_d;
      rd_e         <= instr_d[11:7];
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - randomized and directed self-checking bench for alu_ctrl_stage
module tb_alu_ctrl_stage;

  typedef struct packed {
    logic        v;
    logic [2:0]  op;
    logic        src;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } st_t;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, valid_d, stall_e, flush_e;
  logic [31:0] instr_d, pc_d, rd1_d, rd2_d, immext_d;
  logic        valid_e, alusrc_e, illegal_e;
  logic [2:0]  alucontrol_e;
  logic [31:0] rd1_e, rd2_e, immext_e, pc_e;
  logic [4:0]  rd_e;

  int tests = 0;
  int fails = 0;
  st_t m;
  st_t obs;

  assign obs = {valid_e, alucontrol_e, alusrc_e, illegal_e, rd_e, rd1_e, rd2_e, immext_e, pc_e};

  always #5 clk = ~clk;

  alu_ctrl_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d), .stall_e(stall_e), .flush_e(flush_e),
    .valid_e(valid_e), .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e), .illegal_e(illegal_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e), .pc_e(pc_e), .rd_e(rd_e)
  );

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] opc);
    return {imm, 5'd1, f3, rd, opc};
  endfunction

  // Reference decode: table lookup of the ALU funct3 column plus per-class rules
  function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] op, output logic src,
                                  output logic ill);
    logic [2:0] f3map [8];
    logic [7:0] f3legal;
    logic [2:0] f3;
    logic [6:0] f7;
    f3map = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd4, 3'd0, 3'd3, 3'd2};
    f3legal = 8'b1101_0101;
    f3 = ins[14:12];
    f7 = ins[31:25];
    op = 3'd0; src = 1'b0; ill = 1'b0;
    if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011 || ins[6:0] == 7'b1101111) src = 1'b1;
    else if (ins[6:0] == 7'b1100011) begin
      if (f3 == 3'd0) op = 3'd1; else ill = 1'b1;
    end else if (ins[6:0] == 7'b0010011) begin
      if (f3legal[f3]) begin op = f3map[f3]; src = 1'b1; end else ill = 1'b1;
    end else if (ins[6:0] == 7'b0110011) begin
      if (!f3legal[f3]) ill = 1'b1;
      else if (f7 == 7'h00) op = f3map[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 3'd1;
      else ill = 1'b1;
    end else ill = 1'b1;
    if (ill) begin op = 3'd0; src = 1'b0; end
  endfunction

  function automatic st_t bubble();
    st_t b;
    b = '0;
    b.pc = RPC;
    return b;
  endfunction

  function automatic st_t ref_next(input st_t cur);
    st_t n;
    if (reset || flush_e) return bubble();
    if (stall_e) return cur;
    if (!valid_d) return bubble();
    n.v = 1'b1;
    ref_dec(instr_d, n.op, n.src, n.ill);
    n.rd = instr_d[11:7];
    n.rd1 = rd1_d; n.rd2 = rd2_d; n.imm = immext_d; n.pc = pc_d;
    return n;
  endfunction

  // Drive: inputs already set; advance one edge and update the model
  task automatic tick();
    st_t n;
    n = ref_next(m);
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm);
    instr_d = ins; valid_d = v; rd1_d = a; rd2_d = b; immext_d = imm;
    pc_d = pc_d + 32'd4;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    set_in(mk_r(7'h00, 3'd0, 5'd5), 1'b1, 32'd7, 32'd9, 32'd1);
    tick(); tick();
    tests++;
    if (obs !== {1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, RPC}) begin
      fails++; $display("FAIL reset_state got=%h want=bubble", obs);
    end
    reset = 1'b0;
  endtask

  task automatic test_sub();
    set_in(mk_r(7'h20, 3'd0, 5'd3), 1'b1, 32'd10, 32'd3, 32'd0);
    tick();
    tests++;
    if ({valid_e, alucontrol_e, alusrc_e, illegal_e, rd1_e, rd2_e, rd_e} !==
        {1'b1, 3'b001, 1'b0, 1'b0, 32'd10, 32'd3, 5'd3}) begin
      fails++; $display("FAIL sub got=%h want_op=001 rd1=10 rd2=3 rd=3", obs);
    end
  endtask

  task automatic test_itype();
    logic [2:0] f3s [5];
    logic [2:0] want [5];
    f3s  = '{3'd0, 3'd2, 3'd4, 3'd7, 3'd6};
    want = '{3'b000, 3'b101, 3'b100, 3'b010, 3'b011};
    for (int k = 0; k < 5; k++) begin
      set_in(mk_i(12'hC00, f3s[k], 5'd4, 7'b0010011), 1'b1, 32'd1, 32'd2, 32'hFFFF_FC00);
      tick();
      tests++;
      if ({alucontrol_e, alusrc_e, illegal_e, immext_e} !== {want[k], 1'b1, 1'b0, 32'hFFFF_FC00}) begin
        fails++; $display("FAIL itype_f3_%0d got op=%b src=%b ill=%b imm=%h want op=%b src=1 imm=fffffc00",
                          f3s[k], alucontrol_e, alusrc_e, illegal_e, immext_e, want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_in(mk_i(12'd8, 3'd2, 5'd6, 7'b0000011), 1'b1, 32'd100, 32'd0, 32'd8);
    tick();
    tests++;
    if ({alucontrol_e, alusrc_e, illegal_e} !== 5'b000_1_0) begin
      fails++; $display("FAIL lw got op=%b src=%b ill=%b want 000/1/0", alucontrol_e, alusrc_e, illegal_e);
    end
    set_in({7'd0, 5'd2, 5'd1, 3'd0, 5'd8, 7'b1100011}, 1'b1, 32'd5, 32'd5, 32'd16);
    tick();
    tests++;
    if ({alucontrol_e, alusrc_e, illegal_e} !== 5'b001_0_0) begin
      fails++; $display("FAIL beq got op=%b src=%b ill=%b want 001/0/0", alucontrol_e, alusrc_e, illegal_e);
    end
    set_in(mk_r(7'h00, 3'd1, 5'd9), 1'b1, 32'd1, 32'd2, 32'd0);
    tick();
    tests++;
    if ({valid_e, alucontrol_e, alusrc_e, illegal_e, rd_e} !== {1'b1, 3'b000, 1'b0, 1'b1, 5'd9}) begin
      fails++; $display("FAIL sll_illegal got v=%b op=%b src=%b ill=%b rd=%0d want 1/000/0/1/9",
                        valid_e, alucontrol_e, alusrc_e, illegal_e, rd_e);
    end
  endtask

  task automatic test_stall_flush();
    set_in(mk_r(7'h00, 3'd6, 5'd10), 1'b1, 32'hAA, 32'h55, 32'd0);
    tick();
    stall_e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(mk_i(12'd1, 3'd4, 5'd11, 7'b0010011), 1'b1, 32'h1, 32'h2, 32'h3);
      tick();
      tests++;
      if ({valid_e, alucontrol_e, alusrc_e, rd1_e, rd2_e, rd_e} !== {1'b1, 3'b011, 1'b0, 32'hAA, 32'h55, 5'd10}) begin
        fails++; $display("FAIL stall_hold_%0d got=%h want or/011 held", k, obs);
      end
    end
    flush_e = 1'b1;
    tick();
    tests++;
    if (obs !== bubble()) begin
      fails++; $display("FAIL stall_flush got=%h want=%h", obs, bubble());
    end
    stall_e = 1'b0; flush_e = 1'b0;
  endtask

  task automatic test_bubble();
    set_in(32'hFFFF_FFFF, 1'b0, 32'd3, 32'd4, 32'd5);
    tick();
    tests++;
    if ({valid_e, illegal_e, alucontrol_e, pc_e, rd1_e} !== {1'b0, 1'b0, 3'd0, RPC, 32'd0}) begin
      fails++; $display("FAIL invalid_bubble got v=%b ill=%b op=%b pc=%h want 0/0/000 pc=%h",
                        valid_e, illegal_e, alucontrol_e, pc_e, RPC);
    end
  endtask

  task automatic test_reset_during_stall();
    set_in(mk_r(7'h00, 3'd7, 5'd12), 1'b1, 32'd1, 32'd2, 32'd3);
    tick();
    stall_e = 1'b1; reset = 1'b1;
    tick();
    tests++;
    if (obs !== bubble()) begin
      fails++; $display("FAIL reset_over_stall got=%h want=%h", obs, bubble());
    end
    stall_e = 1'b0; reset = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] opcs [8];
    logic [31:0] ins;
    int bad = 0;
    opcs = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0110011, 7'b0000000};
    for (int k = 0; k < 400; k++) begin
      ins = $urandom;
      ins[6:0] = (k % 17 == 0) ? 7'($urandom) : opcs[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0, 1: ins[31:25] = 7'h00;
        2:    ins[31:25] = 7'h20;
        default: ;
      endcase
      set_in(ins, ($urandom_range(0, 9) != 0), $urandom, $urandom, $urandom);
      pc_d = $urandom;
      stall_e = ($urandom_range(0, 7) == 0);
      flush_e = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 31) == 0);
      tick();
      tests++;
      if (obs !== m) begin
        fails++;
        if (bad < 10) $display("FAIL random_%0d instr=%h got=%h want=%h", k, ins, obs, m);
        bad++;
      end
    end
    stall_e = 1'b0; flush_e = 1'b0; reset = 1'b0;
  endtask

  initial begin
    m = bubble();
    reset = 1'b1; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    instr_d = '0; pc_d = 32'h100; rd1_d = '0; rd2_d = '0; immext_d = '0;
    test_reset();
    test_sub();
    test_itype();
    test_back_to_back();
    test_stall_flush();
    test_bubble();
    test_reset_during_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
